risc_prog_loader: RTL and testbench
===================================

# risc_prog_loader

Byte-stream program loader sitting directly upstream of the `risc` core's instruction-memory write port. Accepts a framed program (length byte, payload bytes, optional checksum) over a valid/ready byte interface, writes each payload byte into consecutive instruction addresses, and holds the core in a non-running state until a complete, valid image is loaded. Its `inst_address`/`inst_data`/`inst_we` outputs connect one-to-one to the core's loader inputs.

## Interface
- `ADDR_W`, 7, instruction address width.
- `DATA_W`, 8, instruction byte width.
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a new load. Sampled only in IDLE, DONE, ERR.
- `in_valid` input 1: `in_data` holds a byte.
- `in_data` input DATA_W: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `inst_address` output ADDR_W: instruction write address.
- `inst_data` output DATA_W: instruction write data.
- `inst_we` output 1: one-cycle write strobe.
- `cpu_run` output 1: high only after a successful load.
- `busy` output 1: load in progress.
- `error` output 1: last load failed checksum.
- `words_loaded` output ADDR_W+1: payload bytes written in current/last load.

## Operation
- Byte transfer = `in_valid && in_ready` on a rising edge. No other byte is consumed.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR. Reset → IDLE.
- IDLE/DONE/ERR + `start` → LEN; clears `words_loaded`, checksum accumulator, `error`; drops `cpu_run`.
- LEN: transfer captures N = `in_data`; N = 0 means 2^ADDR_W (128). → DATA.
- DATA: each transfer writes byte k (k = 0..N-1) to address k; accumulator += byte (mod 256); `words_loaded` += 1. After byte N-1 → CSUM (or DONE, see Configuration).
- CSUM: transfer compares `in_data` with accumulator. Equal → DONE; else → ERR.
- DONE: `cpu_run` = 1, `busy` = 0. ERR: `cpu_run` = 0, `error` = 1, `busy` = 0.
- `in_ready` = 1 exactly in LEN, DATA, CSUM. `busy` = 1 in the same states.
- `start` in LEN/DATA/CSUM ignored. `start` and a transfer never coincide (start not sampled in ready states).
- Address never wraps: counter is ADDR_W+1 bits; N=128 writes addresses 0..127.
- Reset mid-load: state IDLE immediately; partial image left in core memory; `cpu_run` stays 0.

## Timing
- Reset values: `in_ready`=0, `inst_address`=0, `inst_data`=0, `inst_we`=0, `cpu_run`=0, `busy`=0, `error`=0, `words_loaded`=0.
- All outputs registered. DATA transfer at edge t → `inst_we`=1 with address k and data valid during cycle t+1; `inst_we` low otherwise. Back-to-back transfers → consecutive `inst_we` cycles.
- `inst_address`/`inst_data` hold last written value when `inst_we`=0.
- `start` at edge t → `in_ready`=1 in cycle t+1.
- Final transfer (checksum, or last payload without checksum) at edge t → `cpu_run`/`error` valid in cycle t+1; final `inst_we` (no-checksum case) also in t+1, same cycle `cpu_run` rises.
- Throughput: one byte per cycle; `in_valid` gaps stall without state change.

## Configuration
- `LOADER_CSUM_EN` defined: CSUM state present, frame = LEN, N payload, checksum; mismatch → ERR.
- Not defined: no CSUM state or accumulator; after byte N-1 → DONE directly; ERR unreachable, `error` tied 0.

## Test plan
- Checksum on: start, stream 03, 11, 22, 33, 66 → writes (0,11),(1,22),(2,33) on consecutive `inst_we` cycles; `cpu_run`=1, `words_loaded`=3, `error`=0.
- Bad checksum: 02, AA, 01, 00 → two writes, then `error`=1, `cpu_run`=0; new `start` clears `error`.
- Length 00 with 128 bytes of value = address, checksum 0xC0 → last write address 127 data 7F, `words_loaded`=128, `cpu_run`=1.
- `in_valid` toggling every other cycle during 04-byte payload → exactly 4 `inst_we` pulses, addresses 0..3, no duplicates.
- `rst` after 2 of 5 payload bytes → next cycle all outputs at reset values; fresh `start` and full frame loads from address 0.
- `start` pulsed during DATA → ignored, load completes normally; checksum off build: 02, 5A, A5 → `cpu_run` rises in same cycle as second `inst_we`.

Source files
------------

// File: rtl/risc_prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : risc_prog_loader_if
//  Purpose  : Byte-stream, instruction-write and status bundle between a
//             program source and risc_prog_loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface risc_prog_loader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] inst_data;
    logic              inst_we;
    logic              cpu_run;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    // Program source side: drives the stream, observes writes and status.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, inst_address, inst_data, inst_we,
        input  cpu_run, busy, error, words_loaded
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, inst_address, inst_data, inst_we,
        output cpu_run, busy, error, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/risc_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : risc_prog_loader
//  Purpose  : Accepts a framed program (length, payload, optional checksum)
//             over a valid/ready byte stream and writes the payload into
//             consecutive instruction addresses of the risc core. The core is
//             released (cpu_run) only after a complete, valid image.
//  Options  : LOADER_CSUM_EN - when defined, a trailing checksum byte (sum of
//             payload mod 2^DATA_W) is required; a mismatch ends in ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module risc_prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    risc_prog_loader_if.slave     bus
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LEN  = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_DONE = 3'd3;
`ifdef LOADER_CSUM_EN
    localparam logic [2:0] c_ST_CSUM = 3'd4;
    localparam logic [2:0] c_ST_ERR  = 3'd5;
`endif

    // A length byte of zero stands for a full 2^ADDR_W image.
    localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;

    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              w_last_byte;
    logic              w_xfer;
    logic              w_start_load;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
`ifdef LOADER_CSUM_EN
    logic [DATA_W-1:0] r_acc;
`endif

    logic              w_in_ready;
    logic              w_busy;
    logic              w_cpu_run;
    logic              w_error;

    assign w_xfer       = bus.in_valid && w_in_ready;
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_last_byte  = (w_cnt_inc == r_len);
    // A load begins only on the transition into LEN from a non-ready state.
    assign w_start_load = (w_next_state == c_ST_LEN) && (r_state != c_ST_LEN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: frame sequencing driven by accepted bytes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) w_next_state = c_ST_LEN;
            end
`ifdef LOADER_CSUM_EN
            c_ST_ERR: begin
                if (bus.start) w_next_state = c_ST_LEN;
            end
`endif
            c_ST_LEN: begin
                if (w_xfer) w_next_state = c_ST_DATA;
            end
            c_ST_DATA: begin
`ifdef LOADER_CSUM_EN
                if (w_xfer && w_last_byte) w_next_state = c_ST_CSUM;
`else
                if (w_xfer && w_last_byte) w_next_state = c_ST_DONE;
`endif
            end
`ifdef LOADER_CSUM_EN
            c_ST_CSUM: begin
                if (w_xfer) begin
                    w_next_state = (bus.in_data == r_acc) ? c_ST_DONE : c_ST_ERR;
                end
            end
`endif
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_cpu_run  = 1'b0;
        w_error    = 1'b0;
        case (r_state)
            c_ST_LEN, c_ST_DATA: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
`ifdef LOADER_CSUM_EN
            c_ST_CSUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_ST_ERR: begin
                w_error = 1'b1;
            end
`endif
            c_ST_DONE: begin
                w_cpu_run = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length capture, payload write strobe, byte count, checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
`ifdef LOADER_CSUM_EN
            r_acc  <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start_load) begin
                r_cnt <= '0;
`ifdef LOADER_CSUM_EN
                r_acc <= '0;
`endif
            end
            if ((r_state == c_ST_LEN) && w_xfer) begin
                r_len <= (bus.in_data == '0) ? c_MAX_LEN : (ADDR_W+1)'(bus.in_data);
            end
            if ((r_state == c_ST_DATA) && w_xfer) begin
                r_we   <= 1'b1;
                r_addr <= r_cnt[ADDR_W-1:0];
                r_data <= bus.in_data;
                r_cnt  <= w_cnt_inc;
`ifdef LOADER_CSUM_EN
                r_acc  <= r_acc + bus.in_data;
`endif
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.busy         = w_busy;
    assign bus.cpu_run      = w_cpu_run;
    assign bus.error        = w_error;
    assign bus.inst_we      = r_we;
    assign bus.inst_address = r_addr;
    assign bus.inst_data    = r_data;
    assign bus.words_loaded = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_risc_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_prog_loader
//  Purpose  : Scoreboard bench for risc_prog_loader. Frames are built from
//             directed and random payloads; expected instruction writes are
//             queued as bytes are sent and checked by an independent monitor.
//             Honours LOADER_CSUM_EN in the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc_prog_loader;

    localparam int c_ADDR_W = 7;
    localparam int c_DATA_W = 8;
`ifdef LOADER_CSUM_EN
    localparam bit c_CSUM_EN = 1'b1;
`else
    localparam bit c_CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    risc_prog_loader_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    risc_prog_loader #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] pl_mem [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.inst_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write at %0t",
                         bus.inst_address, bus.inst_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(bus.inst_address), 32'(e.addr));
                chk("write_data", 32'(bus.inst_data), 32'(e.data));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int idle_for(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    function automatic logic [7:0] sum_of(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + pl_mem[i];
        return s;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},     32'(bus.in_ready),     0);
        chk({tag, "_inst_address"}, 32'(bus.inst_address), 0);
        chk({tag, "_inst_data"},    32'(bus.inst_data),    0);
        chk({tag, "_inst_we"},      32'(bus.inst_we),      0);
        chk({tag, "_cpu_run"},      32'(bus.cpu_run),      0);
        chk({tag, "_busy"},         32'(bus.busy),         0);
        chk({tag, "_error"},        32'(bus.error),        0);
        chk({tag, "_words_loaded"}, 32'(bus.words_loaded), 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int idle);
        bit done = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake_timeout: got in_ready low for 200 cycles, expected byte 0x%0h accepted", b);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_ready", 32'(bus.in_ready),     1);
        chk("start_busy",     32'(bus.busy),         1);
        chk("start_cpu_run",  32'(bus.cpu_run),      0);
        chk("start_error",    32'(bus.error),        0);
        chk("start_words",    32'(bus.words_loaded), 0);
        @(posedge clk);
        #1;
    endtask

    // Loads pl_mem[0..n-1] framed by len_b (and cs when checksums are on).
    task automatic load_frame(input logic [7:0] len_b, input int n, input logic [7:0] cs,
                              input int gap_mode, input int start_at);
        bit exp_run;
        exp_run = c_CSUM_EN ? (cs == sum_of(n)) : 1'b1;
        do_start();
        send_byte(len_b, idle_for(gap_mode));
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(wr_t'{addr: 7'(k), data: pl_mem[k]});
            if (k == start_at) bus.start = 1'b1;
            send_byte(pl_mem[k], idle_for(gap_mode));
            bus.start = 1'b0;
        end
`ifdef LOADER_CSUM_EN
        send_byte(cs, idle_for(gap_mode));
`endif
        @(negedge clk);
        chk("end_cpu_run",  32'(bus.cpu_run),      32'(exp_run));
        chk("end_error",    32'(bus.error),        32'(!exp_run));
        chk("end_busy",     32'(bus.busy),         0);
        chk("end_in_ready", 32'(bus.in_ready),     0);
        chk("end_words",    32'(bus.words_loaded), 32'(n));
        chk("end_inst_we",  32'(bus.inst_we),      32'(!c_CSUM_EN));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()),    0);
        chk("hold_inst_we",   32'(bus.inst_we),     0);
        chk("hold_address",   32'(bus.inst_address), 32'(n - 1));
        chk("hold_data",      32'(bus.inst_data),   32'(pl_mem[n - 1]));
        chk("hold_cpu_run",   32'(bus.cpu_run),     32'(exp_run));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         n;
        logic [7:0] len_b;
        logic [7:0] cs;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Good three-byte frame.
        pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
        load_frame(8'h03, 3, 8'h66, 0, -1);

        // Bad checksum; the following start must clear error.
        pl_mem[0] = 8'hAA; pl_mem[1] = 8'h01;
        load_frame(8'h02, 2, 8'h00, 0, -1);

        // Full 128-byte image via length 0, data = address.
        for (int k = 0; k < 128; k++) pl_mem[k] = 8'(k);
        load_frame(8'h00, 128, 8'hC0, 0, -1);

        // Four bytes with in_valid toggling.
        for (int k = 0; k < 4; k++) pl_mem[k] = 8'($urandom);
        load_frame(8'h04, 4, sum_of(4), 1, -1);

        // Reset after two of five payload bytes.
        for (int k = 0; k < 5; k++) pl_mem[k] = 8'($urandom);
        do_start();
        send_byte(8'h05, 0);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(wr_t'{addr: 7'(k), data: pl_mem[k]});
            send_byte(pl_mem[k], 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        chk("mid_reset_pending", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        load_frame(8'h05, 5, sum_of(5), 0, -1);

        // Start pulsed during DATA must be ignored.
        pl_mem[0] = 8'h5A; pl_mem[1] = 8'hA5;
        load_frame(8'h02, 2, 8'hFF, 0, 0);

        // Random frames: lengths, payloads, gaps, good/bad checksums.
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 128));
            if (n == 128) len_b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h80;
            else          len_b = 8'(n);
            for (int k = 0; k < n; k++) pl_mem[k] = 8'($urandom);
            cs = sum_of(n);
            if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
            load_frame(len_b, n, cs, int'($urandom_range(0, 2)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
